// File: rtl/ready_bits_update_arbiter.sv
// rtl/ready_bits_update_arbiter.sv - per-source FIFOs, round-robin arbiter and same-wfid coalescing for ready-bit updates
module ready_bits_update_arbiter #(
   parameter  int NUM_SRC     = 3,
   parameter  int INFO_LENGTH = 8,
   parameter  int WFID_LENGTH = 6,
   parameter  int WF_PER_CU   = 40,
   parameter  int FIFO_DEPTH  = 4,
   localparam int SRC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_SRC-1:0]             src_valid,
   input  logic [NUM_SRC*WFID_LENGTH-1:0] src_wfid,
   input  logic [NUM_SRC*INFO_LENGTH-1:0] src_bits,
   output logic [NUM_SRC-1:0]             src_ready,
   output logic                           out_en,
   output logic [WFID_LENGTH-1:0]         out_wfid,
   output logic [INFO_LENGTH-1:0]         out_bits,
   output logic                           err_bad_wfid,
   output logic [SRC_W-1:0]               err_src,
   output logic                           busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]       FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [WFID_LENGTH:0]   WF_LIMIT = (WFID_LENGTH + 1)'(WF_PER_CU);
   localparam logic [SRC_W-1:0]       LAST_SRC = SRC_W'(NUM_SRC - 1);

   logic [WFID_LENGTH-1:0] wfid_mem_q [NUM_SRC][FIFO_DEPTH];
   logic [INFO_LENGTH-1:0] bits_mem_q [NUM_SRC][FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q   [NUM_SRC];
   logic [PTR_W-1:0]       rd_ptr_q   [NUM_SRC];
   logic [CNT_W-1:0]       count_q    [NUM_SRC];
   logic [CNT_W-1:0]       count_d    [NUM_SRC];
   logic [WFID_LENGTH-1:0] in_wfid    [NUM_SRC];
   logic [INFO_LENGTH-1:0] in_bits    [NUM_SRC];
   logic [WFID_LENGTH-1:0] head_wfid  [NUM_SRC];
   logic [INFO_LENGTH-1:0] head_bits  [NUM_SRC];

   logic [NUM_SRC-1:0]     nonempty, push, store, bad, pop;
   logic [SRC_W-1:0]       ptr_q, win, scan_idx;
   logic                   grant;
   logic [WFID_LENGTH-1:0] win_wfid;
   logic [INFO_LENGTH-1:0] merged_bits;
   logic                   any_pending_d;
   logic                   err_d;
   logic [SRC_W-1:0]       err_src_d;

   // Unpack source lanes, FIFO heads, handshake and range classification
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         in_wfid[i]   = src_wfid[i*WFID_LENGTH +: WFID_LENGTH];
         in_bits[i]   = src_bits[i*INFO_LENGTH +: INFO_LENGTH];
         head_wfid[i] = wfid_mem_q[i][rd_ptr_q[i]];
         head_bits[i] = bits_mem_q[i][rd_ptr_q[i]];
         nonempty[i]  = (count_q[i] != '0);
         // ready looks only at the current count, so a full FIFO stays not-ready even while popping
         src_ready[i] = !rst && (count_q[i] != FULL_CNT);
         push[i]      = src_valid[i] && src_ready[i];
         store[i]     = push[i] && ({1'b0, in_wfid[i]} < WF_LIMIT);
         bad[i]       = push[i] && !({1'b0, in_wfid[i]} < WF_LIMIT);
      end
   end

   // Round-robin scan of non-empty heads starting at the pointer
   always_comb begin
      grant    = 1'b0;
      win      = '0;
      scan_idx = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         scan_idx = SRC_W'((int'(ptr_q) + k) % NUM_SRC);
         if (!grant && nonempty[scan_idx]) begin
            grant = 1'b1;
            win   = scan_idx;
         end
      end
   end

   // Pop every head that matches the winner's wfid and OR their bits together
   always_comb begin
      win_wfid    = head_wfid[win];
      merged_bits = '0;
      pop         = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant && nonempty[i] && (head_wfid[i] == win_wfid)) begin
            pop[i]      = 1'b1;
            merged_bits = merged_bits | head_bits[i];
         end
      end
   end

   // Next FIFO occupancy and lowest-index bad-wfid report
   always_comb begin
      any_pending_d = 1'b0;
      err_d         = 1'b0;
      err_src_d     = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         count_d[i] = count_q[i] + CNT_W'(store[i]) - CNT_W'(pop[i]);
         if (count_d[i] != '0) any_pending_d = 1'b1;
      end
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (bad[i]) begin
            err_d     = 1'b1;
            err_src_d = SRC_W'(i);
         end
      end
   end

   // FIFO storage; contents are don't-care while the count says empty
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (store[i]) begin
            wfid_mem_q[i][wr_ptr_q[i]] <= in_wfid[i];
            bits_mem_q[i][wr_ptr_q[i]] <= in_bits[i];
         end
      end
   end

   // Control state and registered outputs; reset drops all buffered updates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            count_q[i]  <= '0;
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
         end
         ptr_q        <= '0;
         out_en       <= 1'b0;
         out_wfid     <= '0;
         out_bits     <= '0;
         err_bad_wfid <= 1'b0;
         err_src      <= '0;
         busy         <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            count_q[i] <= count_d[i];
            if (store[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
            if (pop[i])   rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
         end
         if (grant) ptr_q <= (win == LAST_SRC) ? '0 : win + 1'b1;
         out_en       <= grant;
         out_wfid     <= grant ? win_wfid : '0;
         out_bits     <= grant ? merged_bits : '0;
         err_bad_wfid <= err_d;
         err_src      <= err_src_d;
         busy         <= any_pending_d | grant;
      end
   end

endmodule

// File: tb/tb_ready_bits_update_arbiter.sv
// tb/tb_ready_bits_update_arbiter.sv - directed self-checking bench for ready_bits_update_arbiter
module tb_ready_bits_update_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  src_valid;
   logic [17:0] src_wfid;
   logic [23:0] src_bits;
   logic [2:0]  src_ready;
   logic        out_en;
   logic [5:0]  out_wfid;
   logic [7:0]  out_bits;
   logic        err_bad_wfid;
   logic [1:0]  err_src;
   logic        busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   ready_bits_update_arbiter dut (
      .clk(clk), .rst(rst), .src_valid(src_valid), .src_wfid(src_wfid),
      .src_bits(src_bits), .src_ready(src_ready), .out_en(out_en),
      .out_wfid(out_wfid), .out_bits(out_bits), .err_bad_wfid(err_bad_wfid),
      .err_src(err_src), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int s, input int w, input int b);
      src_valid[s]       = 1'b1;
      src_wfid[s*6 +: 6] = 6'(w);
      src_bits[s*8 +: 8] = 8'(b);
   endtask

   task automatic idle();
      src_valid = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      src_valid = '0; src_wfid = '0; src_bits = '0;
      step(); step();
      total_cnt++; if (src_ready !== 3'b000) $display("FAIL rst_ready: got %b want 000", src_ready); else pass_cnt++;
      total_cnt++; if ({out_en, busy, err_bad_wfid} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {out_en, busy, err_bad_wfid}); else pass_cnt++;
      total_cnt++; if ({out_wfid, out_bits, err_src} !== 16'h0) $display("FAIL rst_data: got %h want 0", {out_wfid, out_bits, err_src}); else pass_cnt++;
      rst = 1'b0;
      #1;
      total_cnt++; if (src_ready !== 3'b111) $display("FAIL rst_release_ready: got %b want 111", src_ready); else pass_cnt++;
   endtask

   task automatic test_single();
      drive(0, 5, 8'h81);
      step(); idle();
      total_cnt++; if (out_en !== 1'b0) $display("FAIL single_early: got %b want 0", out_en); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else pass_cnt++;
      step();
      total_cnt++; if (out_en !== 1'b1) $display("FAIL single_en: got %b want 1", out_en); else pass_cnt++;
      total_cnt++; if (out_wfid !== 6'd5) $display("FAIL single_wfid: got %0d want 5", out_wfid); else pass_cnt++;
      total_cnt++; if (out_bits !== 8'h81) $display("FAIL single_bits: got %h want 81", out_bits); else pass_cnt++;
      step();
      total_cnt++; if (out_en !== 1'b0) $display("FAIL single_once: got %b want 0", out_en); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL single_idle: got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      do_reset();
      drive(0, 1, 8'h01); drive(1, 2, 8'h02); drive(2, 3, 8'h04);
      step(); idle();
      total_cnt++; if (out_en !== 1'b0) $display("FAIL rr_early: got %b want 0", out_en); else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         step();
         total_cnt++;
         if (out_en !== 1'b1 || out_wfid !== 6'(1 + k) || out_bits !== 8'(1 << k))
            $display("FAIL rr_first_%0d: got en=%b wfid=%0d bits=%h want en=1 wfid=%0d bits=%h", k, out_en, out_wfid, out_bits, 1 + k, 8'(1 << k));
         else pass_cnt++;
      end
      drive(0, 4, 8'h08); drive(1, 5, 8'h10); drive(2, 6, 8'h20);
      step(); idle();
      total_cnt++; if (out_en !== 1'b0) $display("FAIL rr_gap: got %b want 0", out_en); else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         step();
         total_cnt++;
         if (out_en !== 1'b1 || out_wfid !== 6'(4 + k) || out_bits !== 8'(8 << k))
            $display("FAIL rr_repeat_%0d: got en=%b wfid=%0d bits=%h want en=1 wfid=%0d bits=%h", k, out_en, out_wfid, out_bits, 4 + k, 8'(8 << k));
         else pass_cnt++;
      end
      step();
      total_cnt++; if (out_en !== 1'b0) $display("FAIL rr_end: got %b want 0", out_en); else pass_cnt++;
   endtask

   task automatic test_coalesce();
      drive(0, 7, 8'h01); drive(2, 7, 8'h10);
      step(); idle();
      total_cnt++; if (out_en !== 1'b0) $display("FAIL coal_early: got %b want 0", out_en); else pass_cnt++;
      step();
      total_cnt++;
      if (out_en !== 1'b1 || out_wfid !== 6'd7 || out_bits !== 8'h11)
         $display("FAIL coal_out: got en=%b wfid=%0d bits=%h want en=1 wfid=7 bits=11", out_en, out_wfid, out_bits);
      else pass_cnt++;
      total_cnt++; if (src_ready !== 3'b111) $display("FAIL coal_ready: got %b want 111", src_ready); else pass_cnt++;
      step();
      total_cnt++; if (out_en !== 1'b0) $display("FAIL coal_second: got %b want 0", out_en); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL coal_busy: got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int  k0 = 0, k1 = 0, n0 = 0, n1 = 0;
      bit  adv0, adv1;
      bit  saw_full = 1'b0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         if (out_en === 1'b1) begin
            total_cnt++;
            if (out_wfid >= 6'd8 && out_wfid <= 6'd19) begin
               if (out_wfid !== 6'(8 + n0) || out_bits !== 8'(8'h10 + n0))
                  $display("FAIL bp_src0_%0d: got wfid=%0d bits=%h want wfid=%0d bits=%h", n0, out_wfid, out_bits, 8 + n0, 8'(8'h10 + n0));
               else pass_cnt++;
               n0++;
            end else if (out_wfid >= 6'd24 && out_wfid <= 6'd33) begin
               if (out_wfid !== 6'(24 + n1) || out_bits !== 8'(8'h80 + n1))
                  $display("FAIL bp_src1_%0d: got wfid=%0d bits=%h want wfid=%0d bits=%h", n1, out_wfid, out_bits, 24 + n1, 8'(8'h80 + n1));
               else pass_cnt++;
               n1++;
            end else begin
               $display("FAIL bp_unexpected: got wfid=%0d want a queued wfid", out_wfid);
            end
         end
         src_valid = '0;
         if (k0 < 12) drive(0, 8 + k0, 8'h10 + k0);
         if (k1 < 10) drive(1, 24 + k1, 8'h80 + k1);
         if (k1 < 10 && src_ready[1] === 1'b0) saw_full = 1'b1;
         adv0 = (k0 < 12) && (src_ready[0] === 1'b1);
         adv1 = (k1 < 10) && (src_ready[1] === 1'b1);
         step();
         if (adv0) k0++;
         if (adv1) k1++;
      end
      idle();
      total_cnt++; if (n0 !== 12) $display("FAIL bp_count0: got %0d want 12", n0); else pass_cnt++;
      total_cnt++; if (n1 !== 10) $display("FAIL bp_count1: got %0d want 10", n1); else pass_cnt++;
      total_cnt++; if (saw_full !== 1'b1) $display("FAIL bp_full_seen: got %b want 1", saw_full); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL bp_drained: got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_bad_wfid();
      drive(1, 40, 8'hFF);
      step(); idle();
      total_cnt++; if (err_bad_wfid !== 1'b1 || err_src !== 2'd1) $display("FAIL bad_err: got err=%b src=%0d want err=1 src=1", err_bad_wfid, err_src); else pass_cnt++;
      total_cnt++; if (out_en !== 1'b0) $display("FAIL bad_noout1: got %b want 0", out_en); else pass_cnt++;
      step();
      total_cnt++; if (err_bad_wfid !== 1'b0) $display("FAIL bad_pulse: got %b want 0", err_bad_wfid); else pass_cnt++;
      total_cnt++; if (out_en !== 1'b0) $display("FAIL bad_noout2: got %b want 0", out_en); else pass_cnt++;
      step();
      total_cnt++; if ({out_en, busy} !== 2'b00) $display("FAIL bad_idle: got %b want 00", {out_en, busy}); else pass_cnt++;

      drive(0, 39, 8'h3C); drive(2, 63, 8'hAA);
      step(); idle();
      total_cnt++; if (err_bad_wfid !== 1'b1 || err_src !== 2'd2) $display("FAIL bad_src2: got err=%b src=%0d want err=1 src=2", err_bad_wfid, err_src); else pass_cnt++;
      step();
      total_cnt++;
      if (out_en !== 1'b1 || out_wfid !== 6'd39 || out_bits !== 8'h3C)
         $display("FAIL edge_wfid39: got en=%b wfid=%0d bits=%h want en=1 wfid=39 bits=3c", out_en, out_wfid, out_bits);
      else pass_cnt++;
      total_cnt++; if (err_bad_wfid !== 1'b0) $display("FAIL bad_src2_pulse: got %b want 0", err_bad_wfid); else pass_cnt++;
      step();

      drive(1, 50, 8'h01); drive(2, 40, 8'h02);
      step(); idle();
      total_cnt++; if (err_bad_wfid !== 1'b1 || err_src !== 2'd1) $display("FAIL bad_lowest: got err=%b src=%0d want err=1 src=1", err_bad_wfid, err_src); else pass_cnt++;
      step();
      total_cnt++; if ({out_en, err_bad_wfid} !== 2'b00) $display("FAIL bad_lowest_after: got %b want 00", {out_en, err_bad_wfid}); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      drive(0, 11, 8'h01); drive(1, 12, 8'h02);
      step();
      drive(0, 13, 8'h04); drive(1, 14, 8'h08);
      step(); idle();
      total_cnt++; if (out_en !== 1'b1 || busy !== 1'b1) $display("FAIL mid_pre: got en=%b busy=%b want 1 1", out_en, busy); else pass_cnt++;
      #3;
      rst = 1'b1;
      #1;
      total_cnt++; if ({out_en, busy} !== 2'b00) $display("FAIL mid_async_flags: got %b want 00", {out_en, busy}); else pass_cnt++;
      total_cnt++; if (src_ready !== 3'b000) $display("FAIL mid_async_ready: got %b want 000", src_ready); else pass_cnt++;
      total_cnt++; if (out_wfid !== 6'd0) $display("FAIL mid_async_wfid: got %0d want 0", out_wfid); else pass_cnt++;
      step();
      rst = 1'b0;
      #1;
      total_cnt++; if (src_ready !== 3'b111) $display("FAIL mid_release_ready: got %b want 111", src_ready); else pass_cnt++;
      for (int c = 0; c < 6; c++) begin
         step();
         total_cnt++;
         if (out_en !== 1'b0 || busy !== 1'b0)
            $display("FAIL mid_stale_%0d: got en=%b busy=%b want 0 0", c, out_en, busy);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_coalesce();
      test_backpressure();
      test_bad_wfid();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ready_bits_update_arbiter.md
Name: ready_bits_update_arbiter

Overview:
- Collects register-ready update notifications from NUM_SRC functional-unit writeback ports (e.g. SALU, SIMD, LSU).
- Buffers each source in its own FIFO and round-robin arbitrates one update per cycle.
- Updates heading to the same wavefront are coalesced into a single output.
- Drives the issue stage's ready-bits demux: one registered (en, wfid, bits) triple per cycle.

Parameters:
- NUM_SRC, 3, number of writeback sources.
- INFO_LENGTH, 8, width of the per-wavefront ready-bits update.
- WFID_LENGTH, 6, wavefront id width.
- WF_PER_CU, 40, number of valid wavefront ids (0..WF_PER_CU-1).
- FIFO_DEPTH, 4, entries per source FIFO; power of two, at least 2.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- src_valid  input  NUM_SRC  per-source update valid.
- src_wfid  input  NUM_SRC*WFID_LENGTH  per-source wavefront id; source i occupies bits [i*WFID_LENGTH +: WFID_LENGTH].
- src_bits  input  NUM_SRC*INFO_LENGTH  per-source ready bits; same packing as src_wfid.
- src_ready  output  NUM_SRC  per-source FIFO not full.
- out_en  output  1  update valid to demux en.
- out_wfid  output  WFID_LENGTH  to demux addr.
- out_bits  output  INFO_LENGTH  to demux in.
- err_bad_wfid  output  1  one-cycle pulse: an out-of-range wfid was dropped.
- err_src  output  log2(NUM_SRC) (min 1)  source index of the dropped update.
- busy  output  1  any FIFO non-empty or out_en high.

Behaviour:
- Reset is asynchronous, active-high.
  - While rst is high: all FIFOs empty, round-robin pointer = 0, and out_en, out_wfid, out_bits, err_bad_wfid, err_src, busy, src_ready all = 0.
  - Reset asserted mid-operation discards all buffered updates immediately.
  - First cycle after rst deasserts: src_ready = all ones.
- Push:
  - A source pushes when src_valid[i] && src_ready[i] in the same cycle.
  - src_ready[i] = (count[i] != FIFO_DEPTH). It depends only on the current count: a full FIFO is not ready even if it pops that cycle.
  - A source holds valid/wfid/bits until ready.
  - Push and pop on a non-full FIFO in the same cycle leave the count unchanged.
- Range check:
  - A handshaken update with wfid >= WF_PER_CU is consumed but not stored.
  - The next cycle, err_bad_wfid = 1 and err_src = lowest such source index.
  - If several sources are bad in the same cycle, only the lowest index is reported.
- Arbitration (combinational on FIFO heads):
  - Scan non-empty FIFOs starting at the pointer, wrapping modulo NUM_SRC; the first found is the winner.
  - After a grant, pointer = (winner+1) mod NUM_SRC. With no grant, the pointer holds.
- Coalescing:
  - Every other non-empty head whose wfid equals the winner's wfid pops in the same cycle.
  - Those heads' bits are ORed into the winner's bits.
  - The pointer is based on the winner only.
- Output register:
  - On a grant, next cycle out_en = 1, out_wfid = winner wfid, out_bits = ORed bits.
  - With no grant, next cycle out_en = 0, out_wfid = 0, out_bits = 0.
  - The consumer has no backpressure; every out_en pulse is final.
- Latency:
  - An update pushed in cycle N into an empty FIFO with no contention appears with out_en = 1 in cycle N+2.
  - Throughput is one output per cycle.
- busy is registered: next-cycle value of (any count != 0 after update) OR next out_en.
- Ordering: per-source FIFO order is preserved. There is no ordering guarantee across sources except through coalescing.

Test Plan:
- Reset then single update: src0 pushes wfid=5, bits=0x81 at cycle 2 → out_en=1, out_wfid=5, out_bits=0x81 at cycle 4 only; busy drops afterwards.
- Round-robin: all three sources push distinct wfids 1, 2, 3 in the same cycle with pointer=0 → outputs in order src0, src1, src2 on consecutive cycles; a repeat burst continues fairly from pointer=0 again.
- Coalesce: src0 and src2 push wfid=7 with bits 0x01 and 0x10 in the same cycle → one output wfid=7, bits=0x11; both FIFOs empty; no second output.
- Backpressure: src1 pushes 4 back-to-back while src0 holds a continuous stream → src1_ready=0 once full; held valid is accepted only after a pop; no update lost or duplicated, order preserved.
- Bad wfid: src1 pushes wfid=40, bits=0xFF → handshake completes; err_bad_wfid=1 with err_src=1 for exactly one cycle; out_en never asserts for it.
- Reset mid-burst: assert rst asynchronously with two FIFOs holding entries → out_en, src_ready, busy go 0 immediately; after release, no stale output appears.
